widthadapt_x_to_1_pkt: RTL and testbench
========================================

Name: widthadapt_x_to_1_pkt

Overview:
Generalised wide-to-narrow stream width adapter: splits each p_iwidth input beat into up to p_x sub-words of p_iwidth/p_x bits. Successor to the fixed power-of-two splitter, it adds:
- any integer ratio;
- selectable sub-word order;
- partial final beats via a per-beat sub-word count;
- packet framing via first/last markers.
It sits between wide producers (frame buffers, sensor readout FIFOs) and narrow consumers (UART, SPI, byte-wide pixel paths).

Parameters:
p_iwidth, 32, input beat width; must be an exact multiple of p_x
p_x, 4, max sub-words per beat; any integer >= 1 (power of two not required)
p_msb_first, 1, 1 = highest sub-word emitted first, 0 = lowest first
p_owidth, p_iwidth/p_x, localparam, output width
p_cw, max(1,$clog2(p_x)), localparam, count field width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  input beat valid
i_data  in  p_iwidth  input beat
i_count  in  p_cw  number of valid sub-words minus 1 (0..p_x-1)
i_last  in  1  beat ends a packet
o_ready  out  1  input beat accepted when i_valid & o_ready
o_valid  out  1  output sub-word valid
o_data  out  p_owidth  output sub-word
o_first  out  1  sub-word is the first of its input beat
o_last  out  1  sub-word is the final one of a beat flagged i_last
i_ready  in  1  downstream ready; transfer when o_valid & i_ready

Behaviour:
- One clock domain (i_clk). Synchronous active-high reset on i_rst.
- State: data buffer, remaining counter (0..p_x), sub-word index pointer, stored last flag, first flag.
- Reset:
  - remaining = 0.
  - o_valid = 0, o_first = 0, o_last = 0.
  - o_data is don't-care.
  - Buffer is not reset.
- o_valid = (remaining != 0).
- o_ready = (remaining == 0) | (remaining == 1 & i_ready). This gives full throughput with no bubble between beats. o_ready has a combinational path from i_ready.
- Accept beat:
  - buffer <= i_data; remaining <= i_count+1; last flag <= i_last; first flag <= 1.
  - Pointer <= p_x-1 if p_msb_first, else 0.
- Latency: the first sub-word is on o_data the cycle after acceptance.
- Output transfer with remaining > 1:
  - remaining decrements.
  - Pointer moves down (MSB-first) or up (LSB-first).
  - First flag clears.
- Output transfer with remaining == 1:
  - Reload if an input beat is accepted in the same cycle.
  - Otherwise remaining <= 0.
- Valid sub-words for count c = i_count+1:
  - MSB-first: the top c sub-words, indices p_x-1 down to p_x-c.
  - LSB-first: indices 0 up to c-1.
  - Unused sub-words are never emitted.
- Outputs:
  - o_data = buffer[pointer*p_owidth +: p_owidth].
  - o_first = first flag & o_valid.
  - o_last = last flag & (remaining == 1).
- Output stability: while o_valid & ~i_ready, o_data, o_first and o_last hold stable.
- i_count > p_x-1 (possible when p_x is not a power of two): clamp to p_x-1. An SVA assertion flags it in simulation.
- p_x == 1: degenerates to a single-register pipeline stage. o_first = o_valid. i_count is ignored.
- Reset mid-beat: remaining sub-words are discarded; no output in the cycle after reset.
- Simultaneous last sub-word transfer and new beat acceptance: the new beat's first sub-word is presented the next cycle; o_valid stays high.

Decomposition:
- Shared package widthadapt_pkg holds:
  - typedef enum {MSB_FIRST, LSB_FIRST} order_e;
  - the count-width function, reused by the future narrow-to-wide packer.
- No sub-module needed; the sub-word mux is inline. A combined packer/unpacker is a separate future block.

Test Plan:
- Defaults, i_data=32'hAABBCCDD, i_count=3, i_last=0, i_ready=1:
  - o_data AA,BB,CC,DD on 4 consecutive cycles.
  - o_first on AA only; o_last never asserted.
  - o_ready high in the cycle DD transfers.
- p_msb_first=0, same beat: order DD,CC,BB,AA.
- Back-to-back beats 32'h01020304 then 32'h05060708 (second with i_last=1), i_ready=1:
  - 8 sub-words on 8 consecutive cycles with no bubble.
  - o_last on 08 only.
- Partial beat 32'h11223344, i_count=1, MSB-first: emits only 11,22; o_last on 22 if i_last=1.
- Backpressure: i_ready toggles 1010… during a beat:
  - Each sub-word is held stable while i_ready=0.
  - No sub-word is dropped or duplicated (scoreboard check).
- Non-power-of-two p_x=3, p_iwidth=24, data 24'hABCDEF: emits AB,CD,EF. Reset asserted after AB: o_valid low next cycle; the next beat starts cleanly.

Source files
------------

// File: rtl/widthadapt_pkg.sv
// rtl/widthadapt_pkg.sv - shared types and helpers for the width adapter family
package widthadapt_pkg;

  // Sub-word emission order within one wide beat.
  typedef enum logic {MSB_FIRST, LSB_FIRST} order_e;

  // Width of a sub-word count / index field for a given ratio; never narrower than one bit.
  function automatic int count_width(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/widthadapt_x_to_1_pkt.sv
// rtl/widthadapt_x_to_1_pkt.sv - wide-to-narrow stream splitter with partial beats and packet framing
module widthadapt_x_to_1_pkt
  import widthadapt_pkg::*;
#(
  parameter int  p_iwidth    = 32,
  parameter int  p_x         = 4,
  parameter bit  p_msb_first = 1'b1,
  localparam int p_owidth    = p_iwidth / p_x,
  localparam int p_cw        = count_width(p_x)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [p_iwidth-1:0] i_data,
  input  logic [p_cw-1:0]     i_count,
  input  logic                i_last,
  output logic                o_ready,
  output logic                o_valid,
  output logic [p_owidth-1:0] o_data,
  output logic                o_first,
  output logic                o_last,
  input  logic                i_ready
);

  // Remaining counter must hold 0..p_x inclusive.
  localparam int              p_rw        = $clog2(p_x + 1);
  localparam order_e          c_order     = p_msb_first ? MSB_FIRST : LSB_FIRST;
  localparam logic [p_cw-1:0] c_cnt_max   = p_cw'(p_x - 1);
  localparam logic [p_cw-1:0] c_ptr_start = (c_order == MSB_FIRST) ? c_cnt_max : '0;

  logic [p_iwidth-1:0] buf_q;
  logic [p_rw-1:0]     rem_q, rem_d;
  logic [p_cw-1:0]     ptr_q, ptr_d;
  logic                last_q, last_d;
  logic                first_q, first_d;
  logic [p_cw-1:0]     cnt_clamped;
  logic                accept;
  logic                xfer;

  // Counts beyond the ratio (only reachable for non-power-of-two p_x) saturate.
  assign cnt_clamped = (i_count > c_cnt_max) ? c_cnt_max : i_count;

  assign o_valid = (rem_q != '0);
  // Ready while empty, or while the final sub-word leaves this cycle, so beats chain without a bubble.
  assign o_ready = (rem_q == '0) || ((rem_q == p_rw'(1)) && i_ready);
  assign accept  = i_valid && o_ready;
  assign xfer    = o_valid && i_ready;

  assign o_data  = buf_q[int'(ptr_q) * p_owidth +: p_owidth];
  assign o_first = first_q && o_valid;
  assign o_last  = last_q && (rem_q == p_rw'(1));

  // Next-state: a new beat reloads everything, otherwise a transfer steps to the next sub-word.
  always_comb begin
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    first_d = first_q;
    if (accept) begin
      rem_d   = p_rw'(cnt_clamped) + p_rw'(1);
      ptr_d   = c_ptr_start;
      last_d  = i_last;
      first_d = 1'b1;
    end else if (xfer) begin
      rem_d   = rem_q - p_rw'(1);
      first_d = 1'b0;
      // Pointer only advances while sub-words remain, keeping it inside the buffer.
      if (rem_q != p_rw'(1)) begin
        ptr_d = (c_order == MSB_FIRST) ? ptr_q - p_cw'(1) : ptr_q + p_cw'(1);
      end
    end
  end

  // Data buffer captures each accepted beat; its contents are meaningless while empty, so no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      buf_q <= i_data;
    end
  end

  // Control state; reset discards any sub-words still pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem_q   <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  // An out-of-range sub-word count is a producer bug even though the hardware clamps it.
  a_count_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
    (accept && (p_x > 1)) |-> (int'(i_count) <= p_x - 1));

endmodule

// File: tb/tb_widthadapt_x_to_1_pkt.sv
// tb/tb_widthadapt_x_to_1_pkt.sv - scoreboard bench for widthadapt_x_to_1_pkt
module tb_widthadapt_x_to_1_pkt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid [3];
  logic [31:0] in_data  [3];
  logic [1:0]  in_count [3];
  logic        in_last  [3];
  logic        ov       [3];
  logic        ord      [3];
  logic [7:0]  od       [3];
  logic        of       [3];
  logic        ol       [3];
  logic        ir       [3];

  // 0: 32-bit MSB-first, 1: 32-bit LSB-first, 2: 24-bit ratio 3 MSB-first
  int cfg_x   [3];
  bit cfg_msb [3];

  widthadapt_x_to_1_pkt #(.p_iwidth(32), .p_x(4), .p_msb_first(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid[0]), .i_data(in_data[0]),
    .i_count(in_count[0]), .i_last(in_last[0]), .o_ready(ord[0]), .o_valid(ov[0]),
    .o_data(od[0]), .o_first(of[0]), .o_last(ol[0]), .i_ready(ir[0]));

  widthadapt_x_to_1_pkt #(.p_iwidth(32), .p_x(4), .p_msb_first(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid[1]), .i_data(in_data[1]),
    .i_count(in_count[1]), .i_last(in_last[1]), .o_ready(ord[1]), .o_valid(ov[1]),
    .o_data(od[1]), .o_first(of[1]), .o_last(ol[1]), .i_ready(ir[1]));

  widthadapt_x_to_1_pkt #(.p_iwidth(24), .p_x(3), .p_msb_first(1'b1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid[2]), .i_data(in_data[2][23:0]),
    .i_count(in_count[2]), .i_last(in_last[2]), .o_ready(ord[2]), .o_valid(ov[2]),
    .o_data(od[2]), .o_first(of[2]), .o_last(ol[2]), .i_ready(ir[2]));

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic       eob;
  } exp_t;

  exp_t       exp_q [$];
  int         active;
  int         checks;
  int         errors;
  int         cyc;
  int         xfer_count;
  int         first_xfer_cyc;
  int         last_xfer_cyc;
  int         ready_mode;
  logic       hold_pend [3];
  logic [9:0] held      [3];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: a beat with count c yields c bytes, walking down from the top or up from the bottom.
  function automatic void model_push(int k, logic [31:0] d, logic [1:0] cnt, logic last);
    int   c;
    int   idx;
    exp_t e;
    c = int'(cnt) + 1;
    if (c > cfg_x[k]) c = cfg_x[k];
    for (int j = 0; j < c; j++) begin
      idx     = cfg_msb[k] ? (cfg_x[k] - 1 - j) : j;
      e.data  = 8'((d >> (idx * 8)) & 32'hFF);
      e.first = (j == 0);
      e.last  = last && (j == c - 1);
      e.eob   = (j == c - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Downstream ready pattern: steady, alternating, or random.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      case (ready_mode)
        0:       ir[k] = 1'b1;
        1:       ir[k] = ~ir[k];
        default: ir[k] = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks handshake and hold behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int k = 0; k < 3; k++) hold_pend[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (hold_pend[k]) begin
          chk("hold_valid", ov[k], 1'b1);
          chk("hold_stable", {od[k], of[k], ol[k]}, held[k]);
          hold_pend[k] = 1'b0;
        end
        if (k != active) begin
          if (ov[k]) chk("idle_instance_valid", ov[k], 1'b0);
        end else if (!ov[k]) begin
          chk("ready_when_empty", ord[k], 1'b1);
          chk("first_when_empty", of[k], 1'b0);
          chk("last_when_empty", ol[k], 1'b0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_output", ov[k], 1'b0);
        end else begin
          e = exp_q[0];
          chk("o_ready", ord[k], ir[k] && e.eob);
          if (ir[k]) begin
            void'(exp_q.pop_front());
            chk("o_data", od[k], e.data);
            chk("o_first", of[k], e.first);
            chk("o_last", ol[k], e.last);
            xfer_count++;
            if (xfer_count == 1) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
          end else begin
            hold_pend[k] = 1'b1;
            held[k]      = {od[k], of[k], ol[k]};
          end
        end
      end
    end
  end

  task automatic send(input int k, input logic [31:0] d, input logic [1:0] cnt, input logic last);
    bit done;
    done        = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_count[k] = cnt;
    in_last[k]  = last;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (ord[k]) begin
        model_push(k, d, cnt, last);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid[k] = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < 200 && !empty; t++) begin
      @(posedge clk);
      empty = (exp_q.size() == 0);
    end
    if (!empty) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int  gap;
    bit  seen;
    cfg_x   = '{4, 4, 3};
    cfg_msb = '{1'b1, 1'b0, 1'b1};
    checks = 0; errors = 0; cyc = 0; xfer_count = 0;
    first_xfer_cyc = 0; last_xfer_cyc = 0;
    ready_mode = 0; active = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_count[k] = '0; in_last[k] = 1'b0;
      ir[k] = 1'b1; hold_pend[k] = 1'b0; held[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_valid", ov[k], 1'b0);
      chk("reset_first", of[k], 1'b0);
      chk("reset_last", ol[k], 1'b0);
      chk("reset_ready", ord[k], 1'b1);
    end
    @(posedge clk); #1;

    // Full beat, MSB-first then LSB-first
    active = 0; send(0, 32'hAABBCCDD, 2'd3, 1'b0); drain();
    active = 1; send(1, 32'hAABBCCDD, 2'd3, 1'b0); drain();

    // Back-to-back beats must stream eight sub-words on consecutive cycles
    active = 0; xfer_count = 0;
    send(0, 32'h01020304, 2'd3, 1'b0);
    send(0, 32'h05060708, 2'd3, 1'b1);
    drain();
    chk("b2b_count", xfer_count, 8);
    chk("b2b_span", last_xfer_cyc - first_xfer_cyc, 7);

    // Partial beat
    send(0, 32'h11223344, 2'd1, 1'b1); drain();

    // Alternating backpressure
    ready_mode = 1;
    send(0, 32'hCAFEF00D, 2'd3, 1'b1); drain();
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;

    // Ratio 3, reset after the first sub-word, then a clean beat
    active = 2; xfer_count = 0; seen = 1'b0;
    send(2, 32'h00ABCDEF, 2'd2, 1'b0);
    for (int t = 0; t < 50 && !seen; t++) begin
      @(posedge clk);
      seen = (xfer_count >= 1);
    end
    if (!seen) chk("rst_wait_timeout", 0, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_beat_valid", ov[2], 1'b0);
    @(posedge clk); #1;
    send(2, 32'h00123456, 2'd2, 1'b1); drain();

    // Randomized beats with random backpressure on every instance
    ready_mode = 2;
    for (int g = 0; g < 6; g++) begin
      active = g % 3;
      for (int n = 0; n < 10; n++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
        send(active, $urandom, 2'($urandom_range(0, cfg_x[active] - 1)),
             1'($urandom_range(0, 1)));
      end
      drain();
    end
    ready_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
